traffic_state_seq: RTL and testbench

Upstream sequencer for the traffic-light decoder. Generates the num_of_bit-wide State code that the decoder turns into Red/Yellow/Green. A clock prescaler sets how long each State dwells. A latched pedestrian request can cut the green phase short, subject to a minimum green time.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/traffic_state_seq_if.sv | 39 +++
 rtl/traffic_state_seq_tick_prescaler.sv | 34 +++
 rtl/traffic_state_seq.sv | 93 +++++++++
 tb/tb_traffic_state_seq.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared constants, phase enum and State-to-phase mapping for the
// traffic-light sequencer and its downstream decoder.
package traffic_pkg;

  localparam int NUM_OF_BIT         = 4;
  localparam int YELLOW_LEN         = 2;
  localparam int GREEN_YELLOW_RATIO = 4;

  localparam int GREEN_LEN    = GREEN_YELLOW_RATIO * YELLOW_LEN;
  localparam int YELLOW_FIRST = GREEN_LEN;
  localparam int RED_FIRST    = GREEN_LEN + YELLOW_LEN;
  localparam int STATE_MAX    = (2 ** NUM_OF_BIT) - 1;

  typedef enum logic [1:0] {
    PH_GREEN,
    PH_YELLOW,
    PH_RED
  } phase_e;

  function automatic phase_e phase_of(
    input logic [NUM_OF_BIT-1:0] s
  );
    phase_e ph;
    if (int'(s) < YELLOW_FIRST)
      ph = PH_GREEN;
    else if (int'(s) < RED_FIRST)
      ph = PH_YELLOW;
    else
      ph = PH_RED;
    return ph;
  endfunction

endpackage

// File: rtl/traffic_state_seq_if.sv
// Control/status bundle between the sequencer and its driver.
// TRAFFIC_SEQ_NIGHT_EN adds the night flash-mode request.
interface traffic_state_seq_if
  import traffic_pkg::*;
#(
  parameter int num_of_bit = NUM_OF_BIT
);

  logic                  en;
  logic                  ped_req;
  logic [num_of_bit-1:0] State;
  logic                  step;
  logic                  ped_ack;
`ifdef TRAFFIC_SEQ_NIGHT_EN
  logic                  night;

  modport master (
    output en, ped_req, night,
    input  State, step, ped_ack
  );

  modport slave (
    input  en, ped_req, night,
    output State, step, ped_ack
  );
`else

  modport master (
    output en, ped_req,
    input  State, step, ped_ack
  );

  modport slave (
    input  en, ped_req,
    output State, step, ped_ack
  );
`endif

endinterface

// File: rtl/traffic_state_seq_tick_prescaler.sv
// Clock prescaler: one tick every tick_div enabled cycles.
// Counter holds while en is low.
module tick_prescaler #(
  parameter int tick_div = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(tick_div - 1);

  logic [15:0] div_cnt_q;
  logic [15:0] div_cnt_d;

  assign tick = en && (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (tick)
      div_cnt_d = '0;
    else if (en)
      div_cnt_d = div_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      div_cnt_q <= '0;
    else
      div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/traffic_state_seq.sv
// State sequencer with prescaled stepping and pedestrian green cut.
// TRAFFIC_SEQ_NIGHT_EN enables yellow/red night flashing.
module traffic_state_seq
  import traffic_pkg::*;
#(
  parameter int num_of_bit         = NUM_OF_BIT,
  parameter int green_yellow_ratio = GREEN_YELLOW_RATIO,
  parameter int yellow_len         = YELLOW_LEN,
  parameter int tick_div           = 15,
  parameter int min_green_steps    = 2
) (
  input logic               clk,
  input logic               rst_n,
  traffic_state_seq_if.slave bus
);

  localparam int green_len = green_yellow_ratio * yellow_len;

  localparam logic [num_of_bit-1:0] GREEN_S =
    num_of_bit'(green_len);
  localparam logic [num_of_bit-1:0] MAX_S = '1;
  localparam logic [num_of_bit-1:0] ONE_S =
    num_of_bit'(1);

  logic                  tick;
  logic                  cut;
  logic                  clr;
  logic [num_of_bit-1:0] nxt;

  logic [num_of_bit-1:0] state_q, state_d;
  logic                  step_q, step_d;
  logic                  ack_q, ack_d;
  logic                  pend_q, pend_d;

  tick_prescaler #(
    .tick_div (tick_div)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .tick  (tick)
  );

  always_comb begin
    cut = pend_q
       && (int'(state_q) < green_len)
       && (int'(state_q) >= min_green_steps - 1);

    if (cut)
      nxt = GREEN_S;
    else if (state_q == MAX_S)
      nxt = '0;
    else
      nxt = state_q + ONE_S;
`ifdef TRAFFIC_SEQ_NIGHT_EN
    if (bus.night)
      nxt = (state_q != GREEN_S) ? GREEN_S : MAX_S;
`endif

    // entering yellow serves any request, including one on this edge
    clr    = tick && (nxt == GREEN_S);
    pend_d = clr ? 1'b0 : (pend_q | bus.ped_req);
    ack_d  = clr && (pend_q || bus.ped_req);
`ifdef TRAFFIC_SEQ_NIGHT_EN
    if (bus.night) begin
      pend_d = 1'b0;
      ack_d  = 1'b0;
    end
`endif

    state_d = tick ? nxt : state_q;
    step_d  = tick;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      step_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.State   = state_q;
  assign bus.step    = step_q;
  assign bus.ped_ack = ack_q;

endmodule

// File: tb/tb_traffic_state_seq.sv
// Directed bench for traffic_state_seq: stepping, wrap, pedestrian
// cut, enable freeze and mid-run reset.
module tb_traffic_state_seq;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_bad;

  traffic_state_seq_if #(.num_of_bit(4)) bus ();

  traffic_state_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.step && n < 100);
    chk("step_seen", 32'(bus.step), 1);
  endtask

  task automatic wait_state(input logic [3:0] tgt);
    int n;
    int k;
    k = 0;
    while (bus.State != tgt && k < 20) begin
      wait_step(n);
      k++;
    end
    chk("reach_state", 32'(bus.State), 32'(tgt));
  endtask

  task automatic ped_pulse();
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
  endtask

  initial begin
    int  n;
    bit  moved;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.ped_req = 1'b0;
`ifdef TRAFFIC_SEQ_NIGHT_EN
    bus.night = 1'b0;
`endif

    // reset state
    cyc();
    cyc();
    chk("rst_state", 32'(bus.State), 0);
    chk("rst_step", 32'(bus.step), 0);
    chk("rst_ack", 32'(bus.ped_ack), 0);

    // 1: free run, 15-cycle steps, wrap after 240 cycles
    rst_n = 1'b1;
    bus.en = 1'b1;
    repeat (14) cyc();
    chk("pre_first_step", 32'(bus.step), 0);
    chk("pre_first_state", 32'(bus.State), 0);
    cyc();
    chk("first_step", 32'(bus.step), 1);
    chk("first_state", 32'(bus.State), 1);
    cyc();
    chk("step_one_cycle", 32'(bus.step), 0);
    chk("hold_state", 32'(bus.State), 1);
    wait_step(n);
    chk("period", 32'(n), 14);
    chk("state2", 32'(bus.State), 2);
    for (int i = 3; i <= 16; i++) begin
      wait_step(n);
      chk("period", 32'(n), 15);
      chk("run_state", 32'(bus.State), 32'(i % 16));
    end
    chk("wrap_ack", 32'(bus.ped_ack), 0);

    // 3: request at State 0 waits for minimum green
    ped_pulse();
    wait_step(n);
    chk("t3_s1", 32'(bus.State), 1);
    chk("t3_ack0", 32'(bus.ped_ack), 0);
    wait_step(n);
    chk("t3_cut", 32'(bus.State), 8);
    chk("t3_ack1", 32'(bus.ped_ack), 1);
    wait_step(n);
    chk("t3_s9", 32'(bus.State), 9);
    chk("t3_ack_after", 32'(bus.ped_ack), 0);

    // 2: request at State 5 cuts to first yellow
    wait_state(4'd5);
    ped_pulse();
    wait_step(n);
    chk("t2_cut", 32'(bus.State), 8);
    chk("t2_ack", 32'(bus.ped_ack), 1);
    chk("t2_step", 32'(bus.step), 1);
    cyc();
    chk("t2_ack_pulse", 32'(bus.ped_ack), 0);
    wait_step(n);
    chk("t2_s9", 32'(bus.State), 9);
    wait_step(n);
    chk("t2_s10", 32'(bus.State), 10);

    // 4: request in red stays latched into next green
    wait_state(4'd12);
    ped_pulse();
    for (int i = 13; i <= 17; i++) begin
      wait_step(n);
      chk("t4_state", 32'(bus.State), 32'(i % 16));
      chk("t4_noack", 32'(bus.ped_ack), 0);
    end
    wait_step(n);
    chk("t4_cut", 32'(bus.State), 8);
    chk("t4_ack", 32'(bus.ped_ack), 1);

    // 5: en low at div_cnt 7 freezes everything
    repeat (7) cyc();
    bus.en = 1'b0;
    moved = 1'b0;
    repeat (40) begin
      cyc();
      if (bus.step || bus.State != 4'd8)
        moved = 1'b1;
    end
    chk("t5_frozen", 32'(moved), 0);
    bus.en = 1'b1;
    wait_step(n);
    chk("t5_resume", 32'(n), 8);
    chk("t5_state", 32'(bus.State), 9);

    // 6: reset clears State and pending request
    ped_pulse();
    rst_n = 1'b0;
    cyc();
    chk("t6_state", 32'(bus.State), 0);
    chk("t6_step", 32'(bus.step), 0);
    chk("t6_ack", 32'(bus.ped_ack), 0);
    rst_n = 1'b1;
    wait_step(n);
    chk("t6_period", 32'(n), 15);
    chk("t6_s1", 32'(bus.State), 1);
    wait_state(4'd7);
    wait_step(n);
    chk("t6_yellow", 32'(bus.State), 8);
    chk("t6_noack", 32'(bus.ped_ack), 0);

    // simultaneous request and natural yellow entry
    wait_state(4'd7);
    repeat (14) cyc();
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    chk("sim_step", 32'(bus.step), 1);
    chk("sim_state", 32'(bus.State), 8);
    chk("sim_ack", 32'(bus.ped_ack), 1);
    wait_state(4'd1);
    wait_step(n);
    chk("sim_no_pend", 32'(bus.State), 2);

    $display("%0d/%0d checks passed", n_chk - n_bad, n_chk);
    $finish;
  end

endmodule
